psram_arbiter: RTL and testbench



---
 rtl/psram_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_psram_arbiter.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psram_arbiter.sv
// Round-robin arbiter sharing the psram_ctrl AXI-style port between clients, one fixed burst at a time.
// Define PSRAM_ARB_PRIO_EN to give client 0 strict priority over the round-robin group.
module psram_arbiter #(
  parameter int NUM_CLIENTS = 2,
  parameter int WR_LEN      = 8,
  parameter int RD_LEN      = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       psram_ready,
  input  logic [NUM_CLIENTS-1:0]     c_req,
  input  logic [NUM_CLIENTS-1:0]     c_we,
  input  logic [NUM_CLIENTS*25-1:0]  c_addr,
  input  logic [NUM_CLIENTS*16-1:0]  c_wdata,
  input  logic [NUM_CLIENTS-1:0]     c_wvalid,
  output logic [NUM_CLIENTS-1:0]     c_wready,
  output logic [17:0]                c_rdata,
  output logic [NUM_CLIENTS-1:0]     c_rvalid,
  output logic [NUM_CLIENTS-1:0]     c_done,
  output logic                       c_err,
  output logic [24:0]                awaddr,
  output logic [7:0]                 awlen,
  output logic                       awvalid,
  input  logic                       awready,
  output logic [15:0]                wdata,
  output logic                       wvalid,
  input  logic                       wready,
  input  logic                       bvalid,
  input  logic [1:0]                 bresp,
  output logic                       bready,
  output logic [24:0]                araddr,
  output logic [7:0]                 arlen,
  output logic                       arvalid,
  input  logic                       arready,
  input  logic [17:0]                rdata,
  input  logic                       rvalid,
  output logic                       rready,
  output logic [NUM_CLIENTS-1:0]     grant
);

  localparam int unsigned NC = NUM_CLIENTS;

`ifdef PSRAM_ARB_PRIO_EN
  localparam logic [1:0] RR_FIRST = 2'd1;
`else
  localparam logic [1:0] RR_FIRST = 2'd0;
`endif

  typedef enum logic [2:0] {IDLE, ADDR, WDATA, WRESP, RDATA} state_t;

  state_t                 state_q;
  logic [1:0]             owner_q;
  logic [1:0]             ptr_q;
  logic                   we_q;
  logic [24:0]            addr_q;
  logic [NUM_CLIENTS-1:0] grant_q;
  logic [NUM_CLIENTS-1:0] c_done_q;
  logic [NUM_CLIENTS-1:0] c_rvalid_q;
  logic                   c_err_q;
  logic                   awvalid_q;
  logic                   arvalid_q;
  logic [3:0]             cnt_q;
  logic [17:0]            rdata_q;

  logic [1:0]             win_idx_d;
  logic                   win_found_d;
  logic [1:0]             cand;
  logic [1:0]             ptr_d;

  // Per-client inputs padded to four slots so a 2-bit owner index selects them directly.
  logic [3:0]  req_pad;
  logic [3:0]  we_pad;
  logic [3:0]  wv_pad;
  logic [24:0] addr_arr [4];
  logic [15:0] wd_arr   [4];

  for (genvar g = 0; g < 4; g++) begin : g_pad
    if (g < NUM_CLIENTS) begin : g_on
      assign req_pad[g]  = c_req[g];
      assign we_pad[g]   = c_we[g];
      assign wv_pad[g]   = c_wvalid[g];
      assign addr_arr[g] = c_addr[25*g +: 25];
      assign wd_arr[g]   = c_wdata[16*g +: 16];
    end else begin : g_off
      assign req_pad[g]  = 1'b0;
      assign we_pad[g]   = 1'b0;
      assign wv_pad[g]   = 1'b0;
      assign addr_arr[g] = '0;
      assign wd_arr[g]   = '0;
    end
  end

  // Search starts at ptr_q; with priority enabled client 0 is excluded from the rotation and overrides it.
  always_comb begin
    win_found_d = 1'b0;
    win_idx_d   = '0;
    cand        = '0;
    for (int unsigned i = 0; i < NC; i++) begin
      cand = 2'((32'(ptr_q) + i) % NC);
      if (!win_found_d && req_pad[cand] && (cand >= RR_FIRST)) begin
        win_found_d = 1'b1;
        win_idx_d   = cand;
      end
    end
`ifdef PSRAM_ARB_PRIO_EN
    if (req_pad[0]) begin
      win_found_d = 1'b1;
      win_idx_d   = '0;
    end
`endif
  end

  assign ptr_d = (owner_q == 2'(NC - 1)) ? '0 : owner_q + 2'd1;

  assign wvalid   = (state_q == WDATA) && wv_pad[owner_q];
  assign wdata    = (state_q == WDATA) ? wd_arr[owner_q] : '0;
  assign c_wready = (wvalid && wready) ? grant_q : '0;

  assign awaddr  = awvalid_q ? addr_q : '0;
  assign araddr  = arvalid_q ? addr_q : '0;
  assign awlen   = awvalid_q ? 8'(WR_LEN) : '0;
  assign arlen   = arvalid_q ? 8'(RD_LEN) : '0;
  assign awvalid = awvalid_q;
  assign arvalid = arvalid_q;
  assign bready  = 1'b1;
  assign rready  = 1'b1;
  assign grant   = grant_q;
  assign c_done  = c_done_q;
  assign c_err   = c_err_q;
  assign c_rvalid = c_rvalid_q;
  assign c_rdata = rdata_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      ptr_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      grant_q    <= '0;
      c_done_q   <= '0;
      c_rvalid_q <= '0;
      c_err_q    <= 1'b0;
      awvalid_q  <= 1'b0;
      arvalid_q  <= 1'b0;
      cnt_q      <= '0;
      rdata_q    <= '0;
    end else begin
      c_done_q   <= '0;
      c_err_q    <= 1'b0;
      c_rvalid_q <= '0;
      unique case (state_q)
        IDLE: begin
          if (psram_ready && win_found_d) begin
            owner_q   <= win_idx_d;
            we_q      <= we_pad[win_idx_d];
            addr_q    <= addr_arr[win_idx_d];
            grant_q   <= NUM_CLIENTS'(1) << win_idx_d;
            awvalid_q <= we_pad[win_idx_d];
            arvalid_q <= !we_pad[win_idx_d];
            cnt_q     <= '0;
            state_q   <= ADDR;
          end
        end
        ADDR: begin
          if ((awvalid_q && awready) || (arvalid_q && arready)) begin
            awvalid_q <= 1'b0;
            arvalid_q <= 1'b0;
            state_q   <= we_q ? WDATA : RDATA;
          end
        end
        WDATA: begin
          if (wvalid && wready) begin
            cnt_q <= cnt_q + 4'd1;
            if (cnt_q == 4'(WR_LEN - 1)) state_q <= WRESP;
          end
        end
        WRESP: begin
          if (bvalid) begin
            c_done_q <= grant_q;
            c_err_q  <= (bresp != 2'b00);
            grant_q  <= '0;
            ptr_q    <= ptr_d;
            state_q  <= IDLE;
          end
        end
        RDATA: begin
          if (rvalid) begin
            c_rvalid_q <= grant_q;
            rdata_q    <= rdata;
            cnt_q      <= cnt_q + 4'd1;
            if (cnt_q == 4'(RD_LEN - 1)) begin
              c_done_q <= grant_q;
              grant_q  <= '0;
              ptr_q    <= ptr_d;
              state_q  <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Stray responses outside their phase are dropped by the FSM but flagged in simulation.
  a_rvalid_phase: assert property (@(posedge clk) disable iff (!reset_n) rvalid |-> (state_q == RDATA));
  a_bvalid_phase: assert property (@(posedge clk) disable iff (!reset_n) bvalid |-> (state_q == WRESP));

endmodule

// File: tb/tb_psram_arbiter.sv
// Self-checking bench for psram_arbiter: the bench plays both the clients and psram_ctrl,
// with a queue-free arithmetic model of the arbitration order and the burst protocol.
module tb_psram_arbiter;
  localparam int NCL = 2;
  localparam int WRL = 8;
  localparam int RDL = 4;
`ifdef PSRAM_ARB_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic             clk, reset_n, psram_ready;
  logic [NCL-1:0]   c_req, c_we, c_wvalid, c_wready, c_rvalid, c_done, grant;
  logic [NCL*25-1:0] c_addr;
  logic [NCL*16-1:0] c_wdata;
  logic [17:0]      c_rdata, rdata;
  logic             c_err;
  logic [24:0]      awaddr, araddr;
  logic [7:0]       awlen, arlen;
  logic             awvalid, awready, wvalid, wready, bvalid, bready;
  logic             arvalid, arready, rvalid, rready;
  logic [15:0]      wdata;
  logic [1:0]       bresp;

  int n_chk, n_fail, rr_next;
  logic [24:0] cl_addr [NCL];
  logic        cl_we   [NCL];
  logic [15:0] cl_wd   [NCL][WRL];

  psram_arbiter #(.NUM_CLIENTS(NCL), .WR_LEN(WRL), .RD_LEN(RDL)) dut (
    .clk(clk), .reset_n(reset_n), .psram_ready(psram_ready),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_wvalid(c_wvalid),
    .c_wready(c_wready), .c_rdata(c_rdata), .c_rvalid(c_rvalid), .c_done(c_done), .c_err(c_err),
    .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bresp(bresp), .bready(bready),
    .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rvalid(rvalid), .rready(rready), .grant(grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, fails so far %0d", n_fail);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Next owner: first requester at or after rr_next (cyclic); client 0 pre-empts the search when prioritised.
  function automatic int model_pick(input logic [NCL-1:0] req);
    if (PRIO && req[0]) return 0;
    for (int k = 0; k < NCL; k++) begin
      int c;
      c = (rr_next + k) % NCL;
      if (req[c] && !(PRIO && c == 0)) return c;
    end
    return -1;
  endfunction

  task automatic set_client(input int cl, input logic we, input logic [24:0] addr, input logic [15:0] base);
    cl_we[cl]   = we;
    cl_addr[cl] = addr;
    for (int k = 0; k < WRL; k++) cl_wd[cl][k] = base + 16'(k);
    c_we[cl] = we;
    c_addr[25*cl +: 25] = addr;
  endtask

  // Serves one whole burst for client cl. drop_mode: 0 keep req, 1 drop at done, 2 drop after grant, 3 drop all at done.
  task automatic run_burst(input int cl, input int drop_mode, input logic [1:0] resp, input int abort_at);
    logic [NCL-1:0] oh;
    int cyc, k, d;
    logic cwv, wr, rv;
    logic [17:0] rd;
    oh  = NCL'(1) << cl;
    cyc = 0;
    while (awvalid !== 1'b1 && arvalid !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
    n_chk++;
    if (cyc >= 40) begin
      $display("FAIL addr_wait: no awvalid/arvalid after %0d cycles, required within 40", cyc);
      n_fail++;
      return;
    end
    n_chk++;
    if (grant !== oh) begin
      $display("FAIL grant: got %b required %b", grant, oh);
      n_fail++;
    end
    n_chk++;
    if (cl_we[cl]) begin
      if ({awvalid, arvalid, awaddr, awlen} !== {2'b10, cl_addr[cl], 8'(WRL)}) begin
        $display("FAIL aw_req: got aw/ar=%b%b addr=%h len=%0d required 10 addr=%h len=%0d",
                 awvalid, arvalid, awaddr, awlen, cl_addr[cl], WRL);
        n_fail++;
      end
    end else if ({awvalid, arvalid, araddr, arlen} !== {2'b01, cl_addr[cl], 8'(RDL)}) begin
      $display("FAIL ar_req: got aw/ar=%b%b addr=%h len=%0d required 01 addr=%h len=%0d",
               awvalid, arvalid, araddr, arlen, cl_addr[cl], RDL);
      n_fail++;
    end
    if (drop_mode == 2) c_req[cl] = 1'b0;
    c_addr[25*cl +: 25] = ~cl_addr[cl];
    d = $urandom_range(0, 2);
    for (int i = 0; i < d; i++) begin
      tick();
      n_chk++;
      if ((cl_we[cl] ? {awvalid, awaddr} : {arvalid, araddr}) !== {1'b1, cl_addr[cl]}) begin
        $display("FAIL addr_hold: valid/addr changed while ready low, required addr %h", cl_addr[cl]);
        n_fail++;
      end
    end
    awready = cl_we[cl];
    arready = !cl_we[cl];
    tick();
    awready = 1'b0;
    arready = 1'b0;
    n_chk++;
    if ({awvalid, arvalid} !== 2'b00) begin
      $display("FAIL addr_drop: got aw/ar=%b%b required 00", awvalid, arvalid);
      n_fail++;
    end
    if (cl_we[cl]) begin
      k = 0;
      cyc = 0;
      while (k < WRL && cyc < 100) begin
        if (abort_at != 0 && k == abort_at) return;
        cwv = ($urandom_range(0, 3) != 0);
        wr  = (cyc % 2 == 0);
        c_wvalid[cl] = cwv;
        c_wdata[16*cl +: 16] = cl_wd[cl][k];
        wready = wr;
        #1;
        n_chk++;
        if (wvalid !== cwv || c_wready !== ((cwv && wr) ? oh : '0)) begin
          $display("FAIL w_handshake: got wvalid=%b c_wready=%b required wvalid=%b c_wready=%b",
                   wvalid, c_wready, cwv, (cwv && wr) ? oh : '0);
          n_fail++;
        end
        if (cwv && wr) begin
          n_chk++;
          if (wdata !== cl_wd[cl][k]) begin
            $display("FAIL wdata beat %0d: got %h required %h", k, wdata, cl_wd[cl][k]);
            n_fail++;
          end
          k++;
        end
        tick();
        cyc++;
      end
      n_chk++;
      if (k != WRL) begin
        $display("FAIL w_beats: got %0d beats required %0d", k, WRL);
        n_fail++;
      end
      c_wvalid[cl] = 1'b1;
      wready = 1'b1;
      #1;
      n_chk++;
      if ({wvalid, c_wready} !== '0) begin
        $display("FAIL w_after_burst: got wvalid=%b c_wready=%b required 0", wvalid, c_wready);
        n_fail++;
      end
      c_wvalid[cl] = 1'b0;
      wready = 1'b0;
      d = $urandom_range(0, 3);
      for (int i = 0; i < d; i++) begin
        tick();
        n_chk++;
        if (c_done !== '0) begin
          $display("FAIL done_early: got %b required 0 before bvalid", c_done);
          n_fail++;
        end
      end
      bvalid = 1'b1;
      bresp  = resp;
      tick();
      bvalid = 1'b0;
      bresp  = 2'b00;
      n_chk++;
      if ({c_done, c_err, grant} !== {oh, resp != 2'b00, {NCL{1'b0}}}) begin
        $display("FAIL wresp: got done=%b err=%b grant=%b required done=%b err=%b grant=0",
                 c_done, c_err, grant, oh, resp != 2'b00);
        n_fail++;
      end
    end else begin
      k = 0;
      cyc = 0;
      while (k < RDL && cyc < 100) begin
        rv = ($urandom_range(0, 2) != 0);
        rd = 18'($urandom);
        rvalid = rv;
        rdata  = rd;
        tick();
        cyc++;
        rvalid = 1'b0;
        if (rv) k++;
        n_chk++;
        if (c_rvalid !== (rv ? oh : '0) || (rv && c_rdata !== rd)) begin
          $display("FAIL r_beat: got c_rvalid=%b c_rdata=%h required c_rvalid=%b c_rdata=%h",
                   c_rvalid, c_rdata, rv ? oh : '0, rd);
          n_fail++;
        end
        n_chk++;
        if (c_done !== ((rv && k == RDL) ? oh : '0)) begin
          $display("FAIL r_done: got %b required %b after beat %0d", c_done, (rv && k == RDL) ? oh : '0, k);
          n_fail++;
        end
      end
      n_chk++;
      if (k != RDL || grant !== '0) begin
        $display("FAIL r_end: got beats=%0d grant=%b required beats=%0d grant=0", k, grant, RDL);
        n_fail++;
      end
    end
    c_addr[25*cl +: 25] = cl_addr[cl];
    if (drop_mode == 1) c_req[cl] = 1'b0;
    else if (drop_mode == 3) c_req = '0;
    rr_next = (cl + 1) % NCL;
    tick();
    n_chk++;
    if ({c_done, c_rvalid} !== '0) begin
      $display("FAIL done_pulse: got done=%b rvalid=%b required 0 one cycle later", c_done, c_rvalid);
      n_fail++;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    n_chk++;
    if ({grant, awvalid, arvalid, wvalid, c_done, c_err, c_rvalid, c_wready} !== '0) begin
      $display("FAIL reset_ctrl: got grant=%b aw=%b ar=%b w=%b done=%b err=%b rv=%b wr=%b required all 0",
               grant, awvalid, arvalid, wvalid, c_done, c_err, c_rvalid, c_wready);
      n_fail++;
    end
    n_chk++;
    if ({bready, rready} !== 2'b11) begin
      $display("FAIL reset_ready: got bready=%b rready=%b required 1 1", bready, rready);
      n_fail++;
    end
    n_chk++;
    if ({c_rdata, awaddr, araddr, awlen, arlen, wdata} !== '0) begin
      $display("FAIL reset_data: got rdata=%h awaddr=%h araddr=%h awlen=%h arlen=%h wdata=%h required 0",
               c_rdata, awaddr, araddr, awlen, arlen, wdata);
      n_fail++;
    end
    reset_n = 1'b1;
    rr_next = 0;
    tick();
    n_chk++;
    if ({grant, awvalid, arvalid} !== '0) begin
      $display("FAIL idle_after_reset: got grant=%b aw=%b ar=%b required 0", grant, awvalid, arvalid);
      n_fail++;
    end
  endtask

  task automatic test_ready_gating();
    psram_ready = 1'b0;
    set_client(0, 1'b1, 25'h0001234, 16'h1000);
    c_req = 2'b01;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_chk++;
      if ({grant, awvalid, arvalid} !== '0) begin
        $display("FAIL ready_gate: got grant=%b aw=%b ar=%b required 0 while not ready", grant, awvalid, arvalid);
        n_fail++;
      end
    end
    psram_ready = 1'b1;
    tick();
    n_chk++;
    if (awvalid !== 1'b1) begin
      $display("FAIL ready_latency: got awvalid=%b required 1 one cycle after ready", awvalid);
      n_fail++;
    end
    run_burst(model_pick(c_req), 1, 2'b00, 0);
  endtask

  task automatic test_read();
    set_client(1, 1'b0, 25'h0000040, 16'h0000);
    c_req = 2'b10;
    run_burst(model_pick(c_req), 2, 2'b00, 0);
  endtask

  task automatic test_round_robin();
    set_client(0, 1'b1, 25'($urandom), 16'($urandom));
    set_client(1, 1'b0, 25'($urandom), 16'($urandom));
    c_req = 2'b11;
    for (int b = 0; b < 4; b++) run_burst(model_pick(c_req), (b == 3) ? 3 : 0, 2'($urandom_range(0, 3)), 0);
  endtask

  task automatic test_error_resp();
    logic [1:0] rs [2];
    rs[0] = 2'b10;
    rs[1] = 2'b11;
    for (int i = 0; i < 2; i++) begin
      set_client(0, 1'b1, 25'($urandom), 16'($urandom));
      c_req = 2'b01;
      run_burst(model_pick(c_req), 1, rs[i], 0);
    end
  endtask

  task automatic test_ready_midburst();
    int exp;
    set_client(0, 1'b1, 25'($urandom), 16'($urandom));
    c_req = 2'b01;
    psram_ready = 1'b1;
    exp = model_pick(c_req);
    tick();
    psram_ready = 1'b0;
    run_burst(exp, 0, 2'b00, 0);
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if ({grant, awvalid, arvalid} !== '0) begin
        $display("FAIL ready_block: got grant=%b aw=%b ar=%b required 0 while not ready", grant, awvalid, arvalid);
        n_fail++;
      end
      tick();
    end
    psram_ready = 1'b1;
    tick();
    n_chk++;
    if (grant !== 2'b01) begin
      $display("FAIL ready_return: got grant=%b required 01", grant);
      n_fail++;
    end
    run_burst(model_pick(c_req), 1, 2'b00, 0);
  endtask

  task automatic test_reset_midburst();
    set_client(0, 1'b1, 25'($urandom), 16'($urandom));
    c_req = 2'b01;
    run_burst(model_pick(c_req), 0, 2'b00, 3);
    c_wvalid[0] = 1'b1;
    wready = 1'b1;
    #1;
    n_chk++;
    if ({wvalid, grant} !== 3'b101) begin
      $display("FAIL pre_reset: got wvalid=%b grant=%b required 1 01", wvalid, grant);
      n_fail++;
    end
    reset_n = 1'b0;
    #1;
    n_chk++;
    if ({wvalid, grant, awvalid, arvalid, c_wready} !== '0) begin
      $display("FAIL async_reset: got wvalid=%b grant=%b aw=%b ar=%b c_wready=%b required 0",
               wvalid, grant, awvalid, arvalid, c_wready);
      n_fail++;
    end
    c_wvalid = '0;
    wready = 1'b0;
    c_addr[24:0] = cl_addr[0];
    rr_next = 0;
    tick();
    tick();
    reset_n = 1'b1;
    run_burst(model_pick(c_req), 1, 2'b00, 0);
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    rr_next = 0;
    reset_n = 1'b0;
    psram_ready = 1'b0;
    c_req = '0;
    c_we = '0;
    c_addr = '0;
    c_wdata = '0;
    c_wvalid = '0;
    awready = 1'b0;
    wready = 1'b0;
    bvalid = 1'b0;
    bresp = 2'b00;
    arready = 1'b0;
    rdata = '0;
    rvalid = 1'b0;
    tick();
    test_reset();
    test_ready_gating();
    test_read();
    test_round_robin();
    test_error_resp();
    test_ready_midburst();
    test_reset_midburst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
